// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//   Decouples the instruction cache from Decode with a small FIFO of fetch
//   packets. Each entry holds a fetch PC and a two-slot instruction packet.
//   Both handshake signals (in_ready, out_valid) are derived purely from
//   registered occupancy, so there is no combinational path between the two
//   sides of the queue and no same-cycle bypass from input to output.
//   A flush (branch/exception redirect) empties the queue in one cycle.
//   When the queue is empty the head presents PC 0 and a pair of NOPs.
//
// Parameters:
//   DEPTH     - number of packet entries (power of two, >= 2)
//   PC_WIDTH  - fetch address width
//   PKT_WIDTH - instruction packet width
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset (priority over everything)
//   flush      in   discard queued and same-cycle incoming packets
//   in_valid   in   icache packet valid
//   in_ready   out  queue can accept a packet this cycle
//   in_pc      in   fetch PC of incoming packet
//   in_instr   in   incoming instruction packet
//   out_valid  out  head packet valid toward Decode
//   out_ready  in   Decode consumes head this cycle
//   out_pc     out  head PC (0 when empty)
//   out_instr  out  head packet (NOP pair when empty)
//   count      out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned PKT_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [PKT_WIDTH-1:0]       in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [PKT_WIDTH-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]       FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]       CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PKT_WIDTH-1:0] NOP_PAIR   = PKT_WIDTH'(64'h00000013_00000013);

  // Architectural state
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // Entry storage; not cleared by reset or flush since only pointers and
  // count determine which entries are live.
  logic [PC_WIDTH-1:0]  r_pc_mem    [DEPTH];
  logic [PKT_WIDTH-1:0] r_instr_mem [DEPTH];

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Handshakes come from registered occupancy only.
  assign w_in_ready  = (r_count != FULL_COUNT);
  assign w_out_valid = (r_count != '0);

  // flush suppresses both transfers; rst is handled in the state register.
  assign w_push = in_valid  && w_in_ready  && !flush;
  assign w_pop  = out_ready && w_out_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= in_pc;
      r_instr_mem[r_tail] <= in_instr;
    end
  end

  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_out_valid;
    count     = r_count;
    out_pc    = '0;
    out_instr = NOP_PAIR;
    if (w_out_valid) begin
      out_pc    = r_pc_mem[r_head];
      out_instr = r_instr_mem[r_head];
    end
  end

endmodule
